// File: rtl/gfx256_pixel_writer.sv
// Single-pixel framebuffer writer: accepts one pixel, computes its byte address,
// clips it, and issues one byte-enabled 32-bit memory write per kept pixel.
module gfx256_pixel_writer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  depth_i,
    input  logic [31:0] target_base_i,
    input  logic [15:0] target_size_x_i,
    input  logic [15:0] target_size_y_i,
    input  logic        clip_en_i,
    input  logic [15:0] clip_x0_i,
    input  logic [15:0] clip_y0_i,
    input  logic [15:0] clip_x1_i,
    input  logic [15:0] clip_y1_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [15:0] pix_x_i,
    input  logic [15:0] pix_y_i,
    input  logic [31:0] pix_color_i,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    output logic [3:0]  mem_sel_o,
    output logic        busy_o,
    output logic [15:0] discard_cnt_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, CALC, REQ} state_e;

    // Pixel and configuration snapshot taken at acceptance
    typedef struct packed {
        logic [1:0]    depth;
        logic [AW-1:0] base;
        logic [CW-1:0] size_x;
        logic [CW-1:0] size_y;
        logic          clip_en;
        logic [CW-1:0] cx0;
        logic [CW-1:0] cy0;
        logic [CW-1:0] cx1;
        logic [CW-1:0] cy1;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [31:0]   color;
    } pix_t;

    state_e        state_q, state_d;
    pix_t          pix_q, pix_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          req_q, req_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [CW-1:0] disc_q, disc_d;

    logic [AW-1:0] offs_c;
    logic [AW-1:0] pix_off_c;
    logic [AW-1:0] adr_c;
    logic [31:0]   dat_c;
    logic [3:0]    sel_c;
    logic          keep_c;

    // Address, data lanes and keep decision from the latched snapshot
    always_comb begin
        offs_c    = AW'(pix_q.y) * AW'(pix_q.size_x) + AW'(pix_q.x);
        pix_off_c = offs_c;
        dat_c     = pix_q.color;
        case (pix_q.depth)
            2'b00:   pix_off_c = offs_c;
            2'b01:   pix_off_c = offs_c << 1;
            2'b11:   pix_off_c = offs_c << 2;
            default: pix_off_c = offs_c;
        endcase
        adr_c = pix_q.base + pix_off_c;
        case (pix_q.depth)
            2'b00: begin
                dat_c = {4{pix_q.color[7:0]}};
                sel_c = 4'(4'b0001 << adr_c[1:0]);
            end
            2'b01: begin
                dat_c = {2{pix_q.color[15:0]}};
                sel_c = adr_c[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dat_c = pix_q.color;
                sel_c = 4'b1111;
            end
        endcase
        keep_c = (pix_q.x < pix_q.size_x) && (pix_q.y < pix_q.size_y) && (pix_q.depth != 2'b10);
        if (pix_q.clip_en) begin
            keep_c = keep_c && (pix_q.x >= pix_q.cx0) && (pix_q.x < pix_q.cx1)
                            && (pix_q.y >= pix_q.cy0) && (pix_q.y < pix_q.cy1);
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        req_d   = req_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        disc_d  = disc_q;
        case (state_q)
            IDLE: begin
                if (pix_valid_i && ready_q) begin
                    pix_d = '{depth: depth_i, base: target_base_i,
                              size_x: target_size_x_i, size_y: target_size_y_i,
                              clip_en: clip_en_i, cx0: clip_x0_i, cy0: clip_y0_i,
                              cx1: clip_x1_i, cy1: clip_y1_i,
                              x: pix_x_i, y: pix_y_i, color: pix_color_i};
                    state_d = CALC;
                end
            end
            CALC: begin
                if (keep_c) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    adr_d   = adr_c;
                    dat_d   = dat_c;
                    sel_d   = sel_c;
                end else begin
                    state_d = IDLE;
                    disc_d  = (disc_q == {CW{1'b1}}) ? disc_q : disc_q + CW'(1);
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pix_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            disc_q  <= disc_d;
        end
    end

    assign pix_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign mem_req_o     = req_q;
    assign mem_adr_o     = adr_q;
    assign mem_dat_o     = dat_q;
    assign mem_sel_o     = sel_q;
    assign discard_cnt_o = disc_q;

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Directed scoreboard bench for gfx256_pixel_writer: expected writes are queued
// when a pixel is offered and popped when the memory request appears.
module tb_gfx256_pixel_writer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  depth_i;
    logic [31:0] target_base_i;
    logic [15:0] target_size_x_i, target_size_y_i;
    logic        clip_en_i;
    logic [15:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic [15:0] pix_x_i, pix_y_i;
    logic [31:0] pix_color_i;
    logic        mem_req_o;
    logic        mem_ack_i;
    logic [31:0] mem_adr_o, mem_dat_o;
    logic [3:0]  mem_sel_o;
    logic        busy_o;
    logic [15:0] discard_cnt_o;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    gfx256_pixel_writer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .depth_i(depth_i), .target_base_i(target_base_i),
        .target_size_x_i(target_size_x_i), .target_size_y_i(target_size_y_i),
        .clip_en_i(clip_en_i), .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i),
        .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .pix_color_i(pix_color_i),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o),
        .busy_o(busy_o), .discard_cnt_o(discard_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] d, input logic [31:0] b, input logic [15:0] sx, input logic [15:0] sy);
        depth_i = d; target_base_i = b; target_size_x_i = sx; target_size_y_i = sy;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        e.adr = a; e.dat = d; e.sel = s;
        sb.push_back(e);
    endtask

    // Offer a pixel; returns at posedge+1 of the accepting edge
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [31:0] c, output int waits);
        waits = 0;
        pix_x_i = x; pix_y_i = y; pix_color_i = c; pix_valid_i = 1'b1;
        while (!pix_ready_o && waits < 20) begin
            @(posedge clk_i); #1;
            waits++;
        end
        chk("ready_timeout", 32'(waits < 20), 32'd1);
        @(posedge clk_i); #1;
        pix_valid_i = 1'b0;
    endtask

    task automatic expect_write(input int ack_delay);
        int   lat;
        exp_t e;
        lat = 0;
        while (!mem_req_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk("req_latency", 32'(lat), 32'd2);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("adr", mem_adr_o, e.adr);
            chk("dat", mem_dat_o, e.dat);
            chk("sel", 32'(mem_sel_o), 32'(e.sel));
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk_i);
                chk("hold_req", 32'(mem_req_o), 32'd1);
                chk("hold_ready", 32'(pix_ready_o), 32'd0);
                chk("hold_adr", mem_adr_o, e.adr);
                chk("hold_dat", mem_dat_o, e.dat);
                chk("hold_sel", 32'(mem_sel_o), 32'(e.sel));
            end
        end
        mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        chk("ack_req", 32'(mem_req_o), 32'd0);
        chk("ack_adr", mem_adr_o, 32'd0);
        chk("ack_dat", mem_dat_o, 32'd0);
        chk("ack_sel", 32'(mem_sel_o), 32'd0);
        chk("ack_ready", 32'(pix_ready_o), 32'd1);
    endtask

    initial begin
        int w;
        rst_ni = 1'b0; pix_valid_i = 1'b0; mem_ack_i = 1'b0;
        pix_x_i = '0; pix_y_i = '0; pix_color_i = '0;
        clip_en_i = 1'b0; clip_x0_i = '0; clip_y0_i = '0; clip_x1_i = '0; clip_y1_i = '0;
        cfg(2'b11, 32'h1000, 16'd640, 16'd480);

        repeat (2) @(negedge clk_i);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_adr", mem_adr_o, 32'd0);
        chk("rst_dat", mem_dat_o, 32'd0);
        chk("rst_sel", 32'(mem_sel_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_disc", 32'(discard_cnt_o), 32'd0);
        chk("rst_ready", 32'(pix_ready_o), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("ready_after_rst", 32'(pix_ready_o), 32'd1);

        // 32bpp; configuration scrambled after acceptance must not matter
        push(32'h0000_240C, 32'h1122_3344, 4'b1111);
        send(16'd3, 16'd2, 32'h1122_3344, w);
        cfg(2'b00, 32'hFFFF_0000, 16'd1, 16'd1);
        chk("calc_busy", 32'(busy_o), 32'd1);
        expect_write(0);

        push(32'h0000_2069, 32'hABAB_ABAB, 4'b0010);
        cfg(2'b00, 32'h2000, 16'd100, 16'd100);
        send(16'd5, 16'd1, 32'h0000_00AB, w);
        expect_write(0);

        push(32'h0000_0002, 32'h1234_1234, 4'b1100);
        cfg(2'b01, 32'h0, 16'd320, 16'd240);
        send(16'd1, 16'd0, 32'h0000_1234, w);
        expect_write(0);

        // Clipping: upper bound exclusive, lower bound inclusive
        cfg(2'b11, 32'h1000, 16'd640, 16'd480);
        clip_en_i = 1'b1; clip_x0_i = 16'd10; clip_x1_i = 16'd20; clip_y0_i = 16'd0; clip_y1_i = 16'd10;
        send(16'd20, 16'd5, 32'h5555_5555, w);
        @(negedge clk_i);
        chk("clip_calc_ready", 32'(pix_ready_o), 32'd0);
        @(negedge clk_i);
        chk("clip_no_req", 32'(mem_req_o), 32'd0);
        chk("clip_ready", 32'(pix_ready_o), 32'd1);
        chk("clip_disc", 32'(discard_cnt_o), 32'd1);
        push(32'h0000_1028, 32'h0102_0304, 4'b1111);
        send(16'd10, 16'd0, 32'h0102_0304, w);
        expect_write(0);
        clip_en_i = 1'b0;
        send(16'd640, 16'd0, 32'h0, w);
        repeat (2) @(negedge clk_i);
        chk("oob_no_req", 32'(mem_req_o), 32'd0);
        chk("oob_disc", 32'(discard_cnt_o), 32'd2);

        // Delayed ack, then back-to-back acceptance
        push(32'h0000_1A00, 32'hDEAD_BEEF, 4'b1111);
        send(16'd0, 16'd1, 32'hDEAD_BEEF, w);
        expect_write(5);
        push(32'h0012_CFFC, 32'hCAFE_F00D, 4'b1111);
        send(16'd639, 16'd479, 32'hCAFE_F00D, w);
        chk("accept_after_ack", 32'(w), 32'd0);
        expect_write(0);

        // Reset while in REQ aborts the write; stray ack afterwards is ignored
        cfg(2'b01, 32'h100, 16'd320, 16'd240);
        send(16'd2, 16'd0, 32'h0000_7777, w);
        repeat (2) @(negedge clk_i);
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req_o), 32'd0);
        chk("abort_adr", mem_adr_o, 32'd0);
        chk("abort_sel", 32'(mem_sel_o), 32'd0);
        chk("abort_disc", 32'(discard_cnt_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready", 32'(pix_ready_o), 32'd0);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rerst_ready", 32'(pix_ready_o), 32'd1);
        @(negedge clk_i);
        chk("stray_ack_req", 32'(mem_req_o), 32'd0);
        chk("stray_ack_busy", 32'(busy_o), 32'd0);
        mem_ack_i = 1'b0;
        push(32'h0000_0386, 32'hBEEF_BEEF, 4'b1100);
        send(16'd3, 16'd1, 32'h0000_BEEF, w);
        expect_write(0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gfx256_pixel_writer.md
GFX256_PIXEL_WRITER -- requirements
Module: gfx256_pixel_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed clock first, then reset.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-002 The configuration inputs SHALL be:
- depth_i  in  2  colour depth, same coding as control register bits[1:0] (00 = 8bpp, 01 = 16bpp, 11 = 32bpp, 10 = illegal).
- target_base_i  in  32  byte address of target buffer.
- target_size_x_i, target_size_y_i  in  16 each  target dimensions in pixels.
- clip_en_i  in  1  clipping enable (control bit 5).
- clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i  in  16 each  clip rectangle.
REQ-003 The pixel input port SHALL be:
- pix_valid_i  in  1  pixel offered.
- pix_ready_o  out  1  pixel accepted when valid and ready are both high.
- pix_x_i, pix_y_i  in  16 each  pixel coordinates.
- pix_color_i  in  32  pixel colour, right-justified.
REQ-004 The memory write port SHALL be:
- mem_req_o  out  1  write request.
- mem_ack_i  in  1  write completed.
- mem_adr_o  out  32  byte address.
- mem_dat_o  out  32  write data.
- mem_sel_o  out  4  byte enables.
REQ-005 The status outputs SHALL be:
- busy_o  out  1  high whenever the state is not IDLE.
- discard_cnt_o  out  16  number of dropped pixels, saturating.

Function
REQ-006 The FSM SHALL have three states: IDLE, CALC and REQ; pix_ready_o SHALL equal (state == IDLE).
REQ-007 On acceptance in IDLE, the block SHALL latch x, y, colour and all configuration inputs, then go to CALC; configuration changes after acceptance SHALL have no effect on that pixel.
REQ-008 In CALC, the block SHALL register offs = y*size_x + x, computed in 32 bits with wrap on overflow.
REQ-009 In CALC, the block SHALL evaluate the keep condition:
- x < size_x and y < size_y;
- depth != 10;
- if clip_en is set, additionally x0 <= x < x1 and y0 <= y < y1 (lower bound inclusive, upper bound exclusive).
REQ-010 If the keep condition fails, CALC SHALL return to IDLE with no request issued, and discard_cnt_o SHALL increment by 1, holding at 0xFFFF once reached.
REQ-011 If the keep condition holds, CALC SHALL go to REQ, and mem_req_o SHALL rise on the cycle REQ is entered (the second rising edge after acceptance); mem_adr_o, mem_dat_o and mem_sel_o SHALL be valid and stable in the same cycle.
REQ-012 The address SHALL be mem_adr_o = target_base + pixel offset (mod 2^32), where the pixel offset is:
- depth 00: offs;
- depth 01: offs<<1;
- depth 11: offs<<2.
REQ-013 Data and byte enables SHALL be:
- depth 00: mem_dat_o = colour[7:0] replicated ×4; mem_sel_o = 0001 << adr[1:0].
- depth 01: mem_dat_o = colour[15:0] replicated ×2; mem_sel_o = adr[1] ? 1100 : 0011.
- depth 11: mem_dat_o = colour; mem_sel_o = 1111.
REQ-014 The block SHALL hold mem_req_o and all memory outputs stable in REQ until mem_ack_i is sampled high; on that edge mem_req_o SHALL drop and the state SHALL return to IDLE.
REQ-015 Maximum throughput SHALL be one pixel per 3 cycles with a zero-wait ack; mem_req_o SHALL never be high in consecutive cycles across two different pixels.
REQ-016 mem_ack_i SHALL be ignored outside REQ.
REQ-017 mem_adr_o, mem_dat_o and mem_sel_o SHALL be 0 whenever mem_req_o is low.

Reset
REQ-018 While rst_ni is low, the block SHALL be in IDLE with:
- mem_req_o = 0;
- mem_adr_o, mem_dat_o, mem_sel_o = 0;
- busy_o = 0;
- discard_cnt_o = 0;
- pix_ready_o = 0.
REQ-019 After rst_ni deasserts, pix_ready_o SHALL go high on the first rising edge.
REQ-020 Assertion of rst_ni in CALC or REQ SHALL abort the in-flight pixel immediately, with no retained request; a later mem_ack_i for the aborted write SHALL be ignored.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- depth 11, base 0x1000, size 640×480, pixel (3,2), colour 0x11223344 -> mem_req_o 2 cycles after accept, adr 0x240C, dat 0x11223344, sel 1111.
- depth 00, base 0x2000, size_x 100, pixel (5,1), colour 0xAB -> adr 0x2069, dat 0xABABABAB, sel 0010.
- depth 01, base 0, size_x 320, pixel (1,0), colour 0x1234 -> adr 0x2, dat 0x12341234, sel 1100.
- clip_en=1, clip x 10..20, pixel (20,5) -> no mem_req_o, discard_cnt_o=1, ready again 2 cycles after accept; pixel (640,0) at size_x 640 -> discard_cnt_o=2.
- ack delayed 5 cycles -> request and outputs held stable, pix_ready_o low throughout, next pixel accepted the cycle after ack.
- rst_ni pulsed low in REQ -> mem_req_o low immediately, discard_cnt_o=0, stray ack ignored, next pixel processed normally.
